// File: rtl/rr_mux_pkg.sv
// Shared constants and types for the round-robin channel multiplexer.
// Exports the arbitration mode encodings and the default channel index type.
package rr_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;

  typedef logic [$clog2(N_DEF)-1:0] ch_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: fixed priority (index 0 first) or round-robin.
// Ports: req (per-channel request), ptr (rr start), mode -> gnt_valid, gnt_idx.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          mode,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt_idx
);

  // Walk the channels starting at the search origin, wrapping at N-1
  // explicitly so a non-power-of-two N never visits a missing channel.
  always_comb begin
    logic [SW-1:0] idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = (mode == MODE_RR) ? ptr : '0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
      idx = (idx == SW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/rr_mux_stage.sv
// Registered N:1 channel mux with per-channel valid/ready handshakes.
// Ports: clk, rst, mode, in_valid/in_data/in_ready, out_valid/out_data/out_sel/out_ready.
module rr_mux_stage
  import rr_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          gnt_valid;
  logic [SW-1:0] gnt_idx;
  logic          load;
  logic          xfer;
  logic [W-1:0]  sel_data;

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .mode      (mode),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Register may refill when empty or being drained this cycle.
  assign load = ~rst & (~out_valid_q | out_ready);
  assign xfer = load & gnt_valid;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SW'(i)) sel_data = in_data[i*W +: W];
    end
  end

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_sel_d   = gnt_idx;
      if (mode == MODE_RR) begin
        ptr_d = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_stage.sv
// Directed scoreboard bench for rr_mux_stage (N=4 main, N=3 wrap check).
// Expected words are queued when a grant is expected and popped after the edge.
module tb_rr_mux_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [3:0]  in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;

  logic [2:0]  in_valid3, in_ready3;
  logic [23:0] in_data3;
  logic        out_valid3, out_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_sel3;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];

  logic [1:0] seq4 [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [1:0] seq3 [4] = '{2'd0, 2'd1, 2'd2, 2'd0};

  rr_mux_stage #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  rr_mux_stage #(.N(3), .W(8)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid3),
    .in_data   (in_data3),
    .in_ready  (in_ready3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .out_sel   (out_sel3),
    .out_ready (out_ready3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic set4(input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  task automatic pop4(input string tag);
    exp_t e;
    if (q4.size() == 0) begin
      chk({tag, "_sb"}, 32'(q4.size()), 32'd1);
    end else begin
      e = q4.pop_front();
      chk({tag, "_v"}, 32'(out_valid), 32'd1);
      chk({tag, "_sel"}, 32'(out_sel), 32'(e.sel));
      chk({tag, "_data"}, 32'(out_data), 32'(e.data));
    end
  endtask

  task automatic pop3(input string tag);
    exp_t e;
    if (q3.size() == 0) begin
      chk({tag, "_sb"}, 32'(q3.size()), 32'd1);
    end else begin
      e = q3.pop_front();
      chk({tag, "_v"}, 32'(out_valid3), 32'd1);
      chk({tag, "_sel"}, 32'(out_sel3), 32'(e.sel));
      chk({tag, "_data"}, 32'(out_data3), 32'(e.data));
    end
  endtask

  initial begin
    rst        = 1'b1;
    mode       = 1'b0;
    in_valid   = 4'hF;
    out_ready  = 1'b1;
    set4(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    in_valid3  = 3'b000;
    in_data3   = 24'h0;
    out_ready3 = 1'b1;

    // 1. reset and idle
    repeat (2) begin
      clk1();
      chk("t1_rst_v", 32'(out_valid), 32'd0);
      chk("t1_rst_data", 32'(out_data), 32'd0);
      chk("t1_rst_sel", 32'(out_sel), 32'd0);
      chk("t1_rst_rdy", 32'(in_ready), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("t1_rdy", 32'(in_ready), 32'h1);
    q4.push_back({2'd0, 8'hA0});
    clk1();
    pop4("t1_out");

    // 2. fixed priority: ch1 always beats ch3
    mode     = 1'b0;
    in_valid = 4'b1010;
    set4(8'h00, 8'h11, 8'h00, 8'h33);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_rdy", 32'(in_ready), 32'b0010);
      q4.push_back({2'd1, 8'h11});
      clk1();
      pop4("t2_out");
    end

    // 3. round-robin sequence and wrap (N=4 and N=3 together)
    mode      = 1'b1;
    in_valid  = 4'hF;
    set4(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    in_valid3 = 3'b111;
    in_data3  = {8'hA2, 8'hA1, 8'hA0};
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t3_rdy", 32'(in_ready), 32'(4'b0001 << seq4[k]));
      q4.push_back({seq4[k], 8'hA0 + 8'(seq4[k])});
      if (k < 4) begin
        chk("t3n3_rdy", 32'(in_ready3), 32'(3'b001 << seq3[k]));
        q3.push_back({seq3[k], 8'hA0 + 8'(seq3[k])});
      end
      clk1();
      pop4("t3_out");
      if (k < 4) pop3("t3n3_out");
      if (k == 3) in_valid3 = 3'b000;
    end
    in_valid = 4'h0;
    clk1();
    chk("t3_drain_v", 32'(out_valid), 32'd0);

    // 4. backpressure; ptr is 2 here
    in_valid = 4'b0100;
    set4(8'hA0, 8'hA1, 8'h5C, 8'hA3);
    #1;
    chk("t4_rdy", 32'(in_ready), 32'b0100);
    q4.push_back({2'd2, 8'h5C});
    clk1();
    pop4("t4_out");
    out_ready = 1'b0;
    in_valid  = 4'hF;
    repeat (3) begin
      #1;
      chk("t4_stall_rdy", 32'(in_ready), 32'd0);
      clk1();
      chk("t4_hold_v", 32'(out_valid), 32'd1);
      chk("t4_hold_data", 32'(out_data), 32'h5C);
      chk("t4_hold_sel", 32'(out_sel), 32'd2);
    end
    out_ready = 1'b1;
    #1;
    chk("t4_resume_rdy", 32'(in_ready), 32'b1000);
    q4.push_back({2'd3, 8'hA3});
    clk1();
    pop4("t4_resume");

    // 5. drain to empty; ptr wrapped to 0
    in_valid = 4'b0001;
    set4(8'h77, 8'hA1, 8'hA2, 8'hA3);
    #1;
    chk("t5_rdy", 32'(in_ready), 32'b0001);
    q4.push_back({2'd0, 8'h77});
    clk1();
    pop4("t5_out");
    in_valid = 4'h0;
    repeat (2) begin
      clk1();
      chk("t5_empty_v", 32'(out_valid), 32'd0);
      chk("t5_keep_data", 32'(out_data), 32'h77);
      chk("t5_keep_sel", 32'(out_sel), 32'd0);
    end

    // 6. reset during a stall with ptr=2
    in_valid = 4'b0010;
    set4(8'hA0, 8'h66, 8'hA2, 8'hA3);
    #1;
    chk("t6_rdy", 32'(in_ready), 32'b0010);
    q4.push_back({2'd1, 8'h66});
    clk1();
    pop4("t6_out");
    out_ready = 1'b0;
    in_valid  = 4'hF;
    set4(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    clk1();
    chk("t6_stall_v", 32'(out_valid), 32'd1);
    chk("t6_stall_data", 32'(out_data), 32'h66);
    rst = 1'b1;
    #1;
    chk("t6_rst_rdy", 32'(in_ready), 32'd0);
    clk1();
    chk("t6_rst_v", 32'(out_valid), 32'd0);
    chk("t6_rst_data", 32'(out_data), 32'd0);
    chk("t6_rst_sel", 32'(out_sel), 32'd0);
    rst = 1'b0;
    #1;
    chk("t6_first_rdy", 32'(in_ready), 32'b0001);
    q4.push_back({2'd0, 8'hA0});
    clk1();
    pop4("t6_first");

    chk("sb_left4", 32'(q4.size()), 32'd0);
    chk("sb_left3", 32'(q3.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
